adapt_sched: RTL

ADAPT_SCHED -- requirements
Module: adapt_sched

---
 rtl/adapt_sched.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/adapt_sched.sv
// Adaptive equalizer scheduler: sequences flush, training, decision-directed
// adaptation and lock, and anneals the LMS step shift between reductions.
//
// state  | meaning
// IDLE   | sequencing disabled, waiting for i_enable
// FLUSH  | letting the equalizer delay line fill
// TRAIN  | adapting against the training reference
// DD     | decision-directed adaptation, counting good symbols
// LOCKED | converged, step frozen, watching for consecutive bad symbols
module adapt_sched #(
  parameter int CNT_W      = 16,
  parameter int MU_W       = 4,
  parameter int FLUSH_SYMS = 16,
  parameter int LOSS_SYMS  = 8
) (
  input  logic             clk,
  input  logic             i_reset,
  input  logic             i_enable,
  input  logic             i_restart,
  input  logic             i_sym_valid,
  input  logic             i_err_small,
  input  logic [CNT_W-1:0] i_train_len,
  input  logic [CNT_W-1:0] i_conv_len,
  input  logic [CNT_W-1:0] i_mu_step_len,
  input  logic [MU_W-1:0]  i_mu_init,
  input  logic [MU_W-1:0]  i_mu_final,
  output logic [2:0]       o_state,
  output logic             o_flush,
  output logic             o_train_mode,
  output logic             o_locked,
  output logic             o_adapt_en,
  output logic [MU_W-1:0]  o_mu_shift
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FLUSH  = 3'd1,
    ST_TRAIN  = 3'd2,
    ST_DD     = 3'd3,
    ST_LOCKED = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(FLUSH_SYMS - 1);
  localparam logic [CNT_W-1:0] LOSS_LAST  = CNT_W'(LOSS_SYMS - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] sym_cnt_q, sym_cnt_d;
  logic [CNT_W-1:0] mu_cnt_q, mu_cnt_d;
  logic [CNT_W-1:0] good_cnt_q, good_cnt_d;
  logic [CNT_W-1:0] bad_cnt_q, bad_cnt_d;
  logic [MU_W-1:0]  mu_shift_q, mu_shift_d;
  logic             adapt_en_q, adapt_en_d;

  logic [CNT_W-1:0] train_last, conv_last, step_last;
  logic [CNT_W-1:0] mu_cnt_nx;
  logic [MU_W-1:0]  mu_shift_nx;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  // Config is sampled live; >= compares let a shrunken length take effect at once.
  always_comb begin
    train_last  = i_train_len - CNT_W'(1);
    step_last   = i_mu_step_len - CNT_W'(1);
    conv_last   = (i_conv_len == '0) ? '0 : i_conv_len - CNT_W'(1);
    mu_cnt_nx   = sat_inc(mu_cnt_q);
    mu_shift_nx = mu_shift_q;
    if (i_mu_step_len != '0 && mu_cnt_q >= step_last) begin
      mu_cnt_nx = '0;
      if (i_mu_final > mu_shift_q) mu_shift_nx = mu_shift_q + MU_W'(1);
    end
  end

  always_comb begin
    state_d    = state_q;
    sym_cnt_d  = sym_cnt_q;
    mu_cnt_d   = mu_cnt_q;
    good_cnt_d = good_cnt_q;
    bad_cnt_d  = bad_cnt_q;
    mu_shift_d = mu_shift_q;
    adapt_en_d = i_sym_valid && (state_q inside {ST_TRAIN, ST_DD, ST_LOCKED});

    if (!i_enable) begin
      state_d    = ST_IDLE;
      sym_cnt_d  = '0;
      mu_cnt_d   = '0;
      good_cnt_d = '0;
      bad_cnt_d  = '0;
    end else if (state_q == ST_IDLE || i_restart) begin
      state_d    = ST_FLUSH;
      sym_cnt_d  = '0;
      mu_cnt_d   = '0;
      good_cnt_d = '0;
      bad_cnt_d  = '0;
      mu_shift_d = i_mu_init;
    end else if (i_sym_valid) begin
      case (state_q)
        ST_FLUSH: begin
          if (sym_cnt_q >= FLUSH_LAST) begin
            state_d   = (i_train_len == '0) ? ST_DD : ST_TRAIN;
            sym_cnt_d = '0;
          end else begin
            sym_cnt_d = sat_inc(sym_cnt_q);
          end
        end
        ST_TRAIN: begin
          mu_cnt_d   = mu_cnt_nx;
          mu_shift_d = mu_shift_nx;
          if (sym_cnt_q >= train_last) begin
            state_d    = ST_DD;
            sym_cnt_d  = '0;
            good_cnt_d = '0;
            bad_cnt_d  = '0;
          end else begin
            sym_cnt_d = sat_inc(sym_cnt_q);
          end
        end
        ST_DD: begin
          mu_cnt_d   = mu_cnt_nx;
          mu_shift_d = mu_shift_nx;
          if (!i_err_small) begin
            good_cnt_d = '0;
          end else if (good_cnt_q >= conv_last) begin
            state_d    = ST_LOCKED;
            sym_cnt_d  = '0;
            good_cnt_d = '0;
            bad_cnt_d  = '0;
          end else begin
            good_cnt_d = sat_inc(good_cnt_q);
          end
        end
        ST_LOCKED: begin
          if (i_err_small) begin
            bad_cnt_d = '0;
          end else if (bad_cnt_q >= LOSS_LAST) begin
            // Lock lost: restart annealing from the initial step.
            state_d    = ST_DD;
            sym_cnt_d  = '0;
            mu_cnt_d   = '0;
            good_cnt_d = '0;
            bad_cnt_d  = '0;
            mu_shift_d = i_mu_init;
          end else begin
            bad_cnt_d = sat_inc(bad_cnt_q);
          end
        end
        default: begin
          state_d    = ST_IDLE;
          sym_cnt_d  = '0;
          mu_cnt_d   = '0;
          good_cnt_d = '0;
          bad_cnt_d  = '0;
        end
      endcase
    end else if (!(state_q inside {ST_FLUSH, ST_TRAIN, ST_DD, ST_LOCKED})) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= ST_IDLE;
      sym_cnt_q  <= '0;
      mu_cnt_q   <= '0;
      good_cnt_q <= '0;
      bad_cnt_q  <= '0;
      mu_shift_q <= '0;
      adapt_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sym_cnt_q  <= sym_cnt_d;
      mu_cnt_q   <= mu_cnt_d;
      good_cnt_q <= good_cnt_d;
      bad_cnt_q  <= bad_cnt_d;
      mu_shift_q <= mu_shift_d;
      adapt_en_q <= adapt_en_d;
    end
  end

  assign o_state      = state_q;
  assign o_flush      = (state_q == ST_FLUSH);
  assign o_train_mode = (state_q == ST_TRAIN);
  assign o_locked     = (state_q == ST_LOCKED);
  assign o_adapt_en   = adapt_en_q;
  assign o_mu_shift   = mu_shift_q;

endmodule
